// File: rtl/picorv32_axi_mem_slave.sv
// ---------------------------------------------------------------------------
// picorv32_axi_mem_slave
//
// AXI4-lite responder: a word-organised on-chip SRAM model with byte-strobe
// writes. Read and write channels run independently, with one outstanding
// transaction each. Each channel has a programmable number of wait states,
// and the block flags accesses that fall outside the mapped window.
//
// Ports
//   clk, reset              rising-edge clock, synchronous active-high reset
//   mem_axi_aw*             write address channel (awprot ignored)
//   mem_axi_w*              write data channel with byte strobes
//   mem_axi_b*              write response channel
//   mem_axi_ar*             read address channel (arprot ignored)
//   mem_axi_r*              read data channel
//   err_access              one-cycle pulse when an out-of-range access completes
// ---------------------------------------------------------------------------
module picorv32_axi_mem_slave #(
   parameter int          MEM_WORDS  = 1024,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int          READ_WAIT  = 0,
   parameter int          WRITE_WAIT = 0,
   parameter logic [31:0] ERR_RDATA  = 32'hDEAD_BEEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_axi_awvalid,
   output logic        mem_axi_awready,
   input  logic [31:0] mem_axi_awaddr,
   input  logic [2:0]  mem_axi_awprot,
   input  logic        mem_axi_wvalid,
   output logic        mem_axi_wready,
   input  logic [31:0] mem_axi_wdata,
   input  logic [3:0]  mem_axi_wstrb,
   output logic        mem_axi_bvalid,
   input  logic        mem_axi_bready,
   input  logic        mem_axi_arvalid,
   output logic        mem_axi_arready,
   input  logic [31:0] mem_axi_araddr,
   input  logic [2:0]  mem_axi_arprot,
   output logic        mem_axi_rvalid,
   input  logic        mem_axi_rready,
   output logic [31:0] mem_axi_rdata,
   output logic        err_access
);

   localparam int IDX_W = $clog2(MEM_WORDS);
   // One bit wider than an address so a window ending at 4 GiB does not wrap.
   localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(MEM_WORDS) * 33'd4;
   localparam logic [3:0]  RD_LAST  = 4'(READ_WAIT - 1);
   localparam logic [3:0]  WR_LAST  = 4'(WRITE_WAIT - 1);

   typedef enum logic [1:0] {W_IDLE = 2'd0, W_WAIT = 2'd1, W_RESP = 2'd2} w_state_t;
   typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2} r_state_t;

   function automatic logic addr_in_range(input logic [31:0] addr);
      return ({1'b0, addr} >= {1'b0, BASE_ADDR}) && ({1'b0, addr} < END_ADDR);
   endfunction

   function automatic logic [IDX_W-1:0] addr_index(input logic [31:0] addr);
      return IDX_W'((addr - BASE_ADDR) >> 2);
   endfunction

   logic [31:0] mem_r [MEM_WORDS];

   // write channel state
   w_state_t    w_state_r, w_state_n;
   logic [3:0]  w_cnt_r, w_cnt_n;
   logic        aw_got_r, aw_got_n, w_got_r, w_got_n;
   logic [31:0] awaddr_r, wdata_r;
   logic [3:0]  wstrb_r;
   logic        awready_r, wready_r, bvalid_r;
   logic        aw_hs_s, w_hs_s, w_commit_s, w_in_range_s;
   logic [31:0] w_addr_s, w_data_s;
   logic [3:0]  w_strb_s;
   logic [IDX_W-1:0] w_idx_s;

   // read channel state
   r_state_t    r_state_r, r_state_n;
   logic [3:0]  r_cnt_r, r_cnt_n;
   logic [31:0] araddr_r, rdata_r;
   logic        arready_r, rvalid_r, err_r;
   logic        ar_hs_s, r_sample_s, r_in_range_s;
   logic [31:0] r_addr_s;
   logic [IDX_W-1:0] r_idx_s;

   logic        unused_prot_s;
   assign unused_prot_s = ^{mem_axi_awprot, mem_axi_arprot};

   assign aw_hs_s = mem_axi_awvalid && awready_r;
   assign w_hs_s  = mem_axi_wvalid && wready_r;
   assign ar_hs_s = mem_axi_arvalid && arready_r;

   // A beat that is handshaking this cycle has not been latched yet, so the
   // commit path takes it straight from the bus.
   assign w_addr_s     = aw_got_r ? awaddr_r : mem_axi_awaddr;
   assign w_data_s     = w_got_r ? wdata_r : mem_axi_wdata;
   assign w_strb_s     = w_got_r ? wstrb_r : mem_axi_wstrb;
   assign w_in_range_s = addr_in_range(w_addr_s);
   assign w_idx_s      = addr_index(w_addr_s);

   assign r_addr_s     = (r_state_r == R_IDLE) ? mem_axi_araddr : araddr_r;
   assign r_in_range_s = addr_in_range(r_addr_s);
   assign r_idx_s      = addr_index(r_addr_s);

   // Write FSM next state; w_commit_s marks the edge that enters RESP.
   always_comb begin
      w_state_n  = w_state_r;
      w_cnt_n    = w_cnt_r;
      aw_got_n   = aw_got_r;
      w_got_n    = w_got_r;
      w_commit_s = 1'b0;
      case (w_state_r)
         W_IDLE: begin
            aw_got_n = aw_got_r || aw_hs_s;
            w_got_n  = w_got_r || w_hs_s;
            if (aw_got_n && w_got_n) begin
               if (WRITE_WAIT == 0) begin
                  w_state_n  = W_RESP;
                  w_commit_s = 1'b1;
               end else begin
                  w_state_n = W_WAIT;
                  w_cnt_n   = 4'd0;
               end
            end else begin
               w_state_n = W_IDLE;
            end
         end
         W_WAIT: begin
            if (w_cnt_r == WR_LAST) begin
               w_state_n  = W_RESP;
               w_commit_s = 1'b1;
            end else begin
               w_cnt_n = w_cnt_r + 4'd1;
            end
         end
         W_RESP: begin
            if (mem_axi_bready) begin
               w_state_n = W_IDLE;
               aw_got_n  = 1'b0;
               w_got_n   = 1'b0;
            end else begin
               w_state_n = W_RESP;
            end
         end
         default: begin
            w_state_n = W_IDLE;
            aw_got_n  = 1'b0;
            w_got_n   = 1'b0;
         end
      endcase
   end

   // Write FSM registers, beat latches and registered write-channel outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         w_state_r <= W_IDLE;
         w_cnt_r   <= 4'd0;
         aw_got_r  <= 1'b0;
         w_got_r   <= 1'b0;
         awaddr_r  <= 32'd0;
         wdata_r   <= 32'd0;
         wstrb_r   <= 4'd0;
         awready_r <= 1'b0;
         wready_r  <= 1'b0;
         bvalid_r  <= 1'b0;
      end else begin
         w_state_r <= w_state_n;
         w_cnt_r   <= w_cnt_n;
         aw_got_r  <= aw_got_n;
         w_got_r   <= w_got_n;
         if (aw_hs_s) begin
            awaddr_r <= mem_axi_awaddr;
         end
         if (w_hs_s) begin
            wdata_r <= mem_axi_wdata;
            wstrb_r <= mem_axi_wstrb;
         end
         awready_r <= (w_state_n == W_IDLE) && !aw_got_n;
         wready_r  <= (w_state_n == W_IDLE) && !w_got_n;
         bvalid_r  <= (w_state_n == W_RESP);
      end
   end

   // Memory array: strobed bytes written on the commit edge, in range only.
   always_ff @(posedge clk) begin
      if (w_commit_s && w_in_range_s && !reset) begin
         for (int i = 0; i < 4; i++) begin
            if (w_strb_s[i]) begin
               mem_r[w_idx_s][8*i +: 8] <= w_data_s[8*i +: 8];
            end
         end
      end
   end

   // Read FSM next state; r_sample_s marks the edge that enters RESP.
   always_comb begin
      r_state_n  = r_state_r;
      r_cnt_n    = r_cnt_r;
      r_sample_s = 1'b0;
      case (r_state_r)
         R_IDLE: begin
            if (ar_hs_s) begin
               if (READ_WAIT == 0) begin
                  r_state_n  = R_RESP;
                  r_sample_s = 1'b1;
               end else begin
                  r_state_n = R_WAIT;
                  r_cnt_n   = 4'd0;
               end
            end else begin
               r_state_n = R_IDLE;
            end
         end
         R_WAIT: begin
            if (r_cnt_r == RD_LAST) begin
               r_state_n  = R_RESP;
               r_sample_s = 1'b1;
            end else begin
               r_cnt_n = r_cnt_r + 4'd1;
            end
         end
         R_RESP: begin
            if (mem_axi_rready) begin
               r_state_n = R_IDLE;
            end else begin
               r_state_n = R_RESP;
            end
         end
         default: begin
            r_state_n = R_IDLE;
         end
      endcase
   end

   // Read FSM registers and registered read data. Sampling uses the array
   // value before any same-edge write, so a colliding read sees old data.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state_r <= R_IDLE;
         r_cnt_r   <= 4'd0;
         araddr_r  <= 32'd0;
         rdata_r   <= 32'd0;
         arready_r <= 1'b0;
         rvalid_r  <= 1'b0;
      end else begin
         r_state_r <= r_state_n;
         r_cnt_r   <= r_cnt_n;
         if (ar_hs_s) begin
            araddr_r <= mem_axi_araddr;
         end
         if (r_sample_s) begin
            rdata_r <= r_in_range_s ? mem_r[r_idx_s] : ERR_RDATA;
         end
         arready_r <= (r_state_n == R_IDLE);
         rvalid_r  <= (r_state_n == R_RESP);
      end
   end

   // Out-of-range pulse; simultaneous read and write errors merge into one.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_r <= 1'b0;
      end else begin
         err_r <= (w_commit_s && !w_in_range_s) || (r_sample_s && !r_in_range_s);
      end
   end

   assign mem_axi_awready = awready_r;
   assign mem_axi_wready  = wready_r;
   assign mem_axi_bvalid  = bvalid_r;
   assign mem_axi_arready = arready_r;
   assign mem_axi_rvalid  = rvalid_r;
   assign mem_axi_rdata   = rdata_r;
   assign err_access      = err_r;

endmodule

// File: tb/tb_picorv32_axi_mem_slave.sv
// Bench for picorv32_axi_mem_slave. Two instances: dut 0 has no wait states
// (64 words at 0x0), dut 1 has READ_WAIT=3 / WRITE_WAIT=2 (16 words at
// 0x8000_0000). Inputs change and outputs are sampled on the falling edge.
module tb_picorv32_axi_mem_slave;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst [2];
   logic        awvalid [2], awready [2], wvalid [2], wready [2], bvalid [2], bready [2];
   logic        arvalid [2], arready [2], rvalid [2], rready [2], err [2];
   logic [31:0] awaddr [2], wdata [2], araddr [2], rdata [2];
   logic [3:0]  wstrb [2];

   int n_checks = 0;
   int n_fail = 0;
   logic [31:0] exp_q [$];
   logic [31:0] model0 [64];

   picorv32_axi_mem_slave #(.MEM_WORDS(64), .BASE_ADDR(32'h0000_0000), .READ_WAIT(0),
      .WRITE_WAIT(0), .ERR_RDATA(32'hDEAD_BEEF)) dut0 (
      .clk(clk), .reset(rst[0]),
      .mem_axi_awvalid(awvalid[0]), .mem_axi_awready(awready[0]), .mem_axi_awaddr(awaddr[0]),
      .mem_axi_awprot(3'b000), .mem_axi_wvalid(wvalid[0]), .mem_axi_wready(wready[0]),
      .mem_axi_wdata(wdata[0]), .mem_axi_wstrb(wstrb[0]), .mem_axi_bvalid(bvalid[0]),
      .mem_axi_bready(bready[0]), .mem_axi_arvalid(arvalid[0]), .mem_axi_arready(arready[0]),
      .mem_axi_araddr(araddr[0]), .mem_axi_arprot(3'b000), .mem_axi_rvalid(rvalid[0]),
      .mem_axi_rready(rready[0]), .mem_axi_rdata(rdata[0]), .err_access(err[0]));

   picorv32_axi_mem_slave #(.MEM_WORDS(16), .BASE_ADDR(32'h8000_0000), .READ_WAIT(3),
      .WRITE_WAIT(2), .ERR_RDATA(32'hDEAD_BEEF)) dut1 (
      .clk(clk), .reset(rst[1]),
      .mem_axi_awvalid(awvalid[1]), .mem_axi_awready(awready[1]), .mem_axi_awaddr(awaddr[1]),
      .mem_axi_awprot(3'b000), .mem_axi_wvalid(wvalid[1]), .mem_axi_wready(wready[1]),
      .mem_axi_wdata(wdata[1]), .mem_axi_wstrb(wstrb[1]), .mem_axi_bvalid(bvalid[1]),
      .mem_axi_bready(bready[1]), .mem_axi_arvalid(arvalid[1]), .mem_axi_arready(arready[1]),
      .mem_axi_araddr(araddr[1]), .mem_axi_arprot(3'b000), .mem_axi_rvalid(rvalid[1]),
      .mem_axi_rready(rready[1]), .mem_axi_rdata(rdata[1]), .err_access(err[1]));

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] st);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) begin
         if (st[i]) r[8*i +: 8] = nw[8*i +: 8];
      end
      return r;
   endfunction

   // Write transaction; W is offered 'gap' cycles after AW, B is held off for
   // 'hold' cycles. lat counts cycles from the last beat handshake to bvalid.
   task automatic axi_write(input int d, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] st, input int gap, input int hold,
                            output int lat, output int err_cnt, output bit hold_ok,
                            output int aw_low, output bit w_high);
      bit aw_pend, w_pend, hs_aw, hs_w, done;
      int cap, hb;
      lat = -1; err_cnt = 0; hold_ok = 1'b1; aw_low = 0; w_high = 1'b1;
      cap = -1; hb = 0; done = 1'b0; aw_pend = 1'b1; w_pend = 1'b1;
      awaddr[d] = a; wdata[d] = wd; wstrb[d] = st; bready[d] = 1'b0;
      awvalid[d] = 1'b1;
      for (int c = 0; c < 200 && !done; c++) begin
         if (c == gap) wvalid[d] = 1'b1;
         if (c >= 1 && c <= gap) begin
            if (!awready[d]) aw_low++;
            if (!wready[d]) w_high = 1'b0;
         end
         hs_aw = aw_pend && awready[d];
         hs_w  = w_pend && wvalid[d] && wready[d];
         if (err[d]) err_cnt++;
         if (bvalid[d]) begin
            if (lat < 0) lat = c - cap;
            if (hb < hold) begin
               if (awready[d] || wready[d]) hold_ok = 1'b0;
               hb++;
            end else begin
               bready[d] = 1'b1;
               done = 1'b1;
            end
         end else if (lat >= 0) begin
            hold_ok = 1'b0;
         end
         @(negedge clk);
         if (hs_aw) begin awvalid[d] = 1'b0; aw_pend = 1'b0; end
         if (hs_w) begin wvalid[d] = 1'b0; w_pend = 1'b0; end
         if ((hs_aw || hs_w) && !aw_pend && !w_pend) cap = c;
      end
      bready[d] = 1'b0;
      awvalid[d] = 1'b0; wvalid[d] = 1'b0;
      if (err[d]) err_cnt++;
      if (bvalid[d] || !awready[d] || !wready[d]) hold_ok = 1'b0;
   endtask

   // Read transaction; R is held off for 'hold' cycles. lat counts cycles
   // from the AR handshake to rvalid.
   task automatic axi_read(input int d, input logic [31:0] a, input int hold,
                           output logic [31:0] data, output int lat, output int err_cnt,
                           output bit hold_ok);
      bit pend, hs, done;
      int cap, hb;
      data = 32'd0; lat = -1; err_cnt = 0; hold_ok = 1'b1;
      cap = -1; hb = 0; done = 1'b0; pend = 1'b1;
      araddr[d] = a; arvalid[d] = 1'b1; rready[d] = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
         hs = pend && arready[d];
         if (err[d]) err_cnt++;
         if (rvalid[d]) begin
            if (lat < 0) begin lat = c - cap; data = rdata[d]; end
            if (hb < hold) begin
               if (arready[d] || (rdata[d] !== data)) hold_ok = 1'b0;
               hb++;
            end else begin
               rready[d] = 1'b1;
               done = 1'b1;
            end
         end else if (lat >= 0) begin
            hold_ok = 1'b0;
         end
         @(negedge clk);
         if (hs) begin arvalid[d] = 1'b0; pend = 1'b0; cap = c; end
      end
      rready[d] = 1'b0;
      arvalid[d] = 1'b0;
      if (err[d]) err_cnt++;
      if (rvalid[d] || !arready[d]) hold_ok = 1'b0;
   endtask

   task automatic test_reset();
      logic [5:0] st;
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1;
         awvalid[d] = 1'b0; wvalid[d] = 1'b0; bready[d] = 1'b0; arvalid[d] = 1'b0; rready[d] = 1'b0;
         awaddr[d] = 32'd0; wdata[d] = 32'd0; wstrb[d] = 4'd0; araddr[d] = 32'd0;
      end
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         st = {awready[d], wready[d], arready[d], bvalid[d], rvalid[d], err[d]};
         n_checks++; if (st !== 6'b000000) begin n_fail++; $display("FAIL reset_outs dut%0d: got %b expected %b", d, st, 6'b000000); end
         n_checks++; if (rdata[d] !== 32'd0) begin n_fail++; $display("FAIL reset_rdata dut%0d: got %h expected %h", d, rdata[d], 32'd0); end
         rst[d] = 1'b0;
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         st = {awready[d], wready[d], arready[d], bvalid[d], rvalid[d], err[d]};
         n_checks++; if (st !== 6'b111000) begin n_fail++; $display("FAIL reset_release dut%0d: got %b expected %b", d, st, 6'b111000); end
      end
   endtask

   task automatic test_write_read();
      int lat, ec, al; bit ok, wh; logic [31:0] data, e;
      axi_write(0, 32'h10, 32'hA5A5_1234, 4'hF, 0, 0, lat, ec, ok, al, wh);
      model0[4] = merge(model0[4], 32'hA5A5_1234, 4'hF);
      n_checks++; if (lat !== 1 || ec !== 0 || !ok) begin n_fail++; $display("FAIL wr_basic: got lat=%0d err=%0d ok=%0d expected lat=1 err=0 ok=1", lat, ec, ok); end
      exp_q.push_back(model0[4]);
      axi_read(0, 32'h10, 0, data, lat, ec, ok);
      e = exp_q.pop_front();
      n_checks++; if (lat !== 1 || ec !== 0 || !ok) begin n_fail++; $display("FAIL rd_basic_timing: got lat=%0d err=%0d ok=%0d expected lat=1 err=0 ok=1", lat, ec, ok); end
      n_checks++; if (data !== e) begin n_fail++; $display("FAIL rd_basic_data: got %h expected %h", data, e); end
   endtask

   task automatic test_decoupled_strobe();
      int lat, ec, al; bit ok, wh; logic [31:0] data, e;
      axi_write(0, 32'h20, 32'h1122_3344, 4'hF, 0, 0, lat, ec, ok, al, wh);
      model0[8] = merge(model0[8], 32'h1122_3344, 4'hF);
      axi_write(0, 32'h20, 32'hFFFF_FFFF, 4'b0101, 3, 0, lat, ec, ok, al, wh);
      model0[8] = merge(model0[8], 32'hFFFF_FFFF, 4'b0101);
      n_checks++; if (al !== 3 || !wh) begin n_fail++; $display("FAIL decoupled_ready: got awready_low=%0d wready_high=%0d expected 3 1", al, wh); end
      n_checks++; if (lat !== 1 || !ok) begin n_fail++; $display("FAIL decoupled_b: got lat=%0d ok=%0d expected lat=1 ok=1", lat, ok); end
      exp_q.push_back(model0[8]);
      axi_read(0, 32'h23, 0, data, lat, ec, ok);
      e = exp_q.pop_front();
      n_checks++; if (data !== e || e !== 32'h11FF_33FF) begin n_fail++; $display("FAIL strobe_data: got %h expected %h", data, 32'h11FF_33FF); end
   endtask

   task automatic test_backpressure();
      int lat, ec, al; bit ok, wh; logic [31:0] data, e;
      axi_write(1, 32'h8000_0008, 32'hCAFE_0001, 4'hF, 0, 5, lat, ec, ok, al, wh);
      n_checks++; if (lat !== 3 || !ok || ec !== 0) begin n_fail++; $display("FAIL bp_write: got lat=%0d ok=%0d err=%0d expected lat=3 ok=1 err=0", lat, ok, ec); end
      exp_q.push_back(32'hCAFE_0001);
      axi_read(1, 32'h8000_0008, 5, data, lat, ec, ok);
      e = exp_q.pop_front();
      n_checks++; if (lat !== 4 || !ok || ec !== 0) begin n_fail++; $display("FAIL bp_read: got lat=%0d ok=%0d err=%0d expected lat=4 ok=1 err=0", lat, ok, ec); end
      n_checks++; if (data !== e) begin n_fail++; $display("FAIL bp_rdata: got %h expected %h", data, e); end
   endtask

   task automatic test_out_of_range();
      int lat, ec, al; bit ok, wh; logic [31:0] data, e;
      axi_write(0, 32'h0, 32'h0BAD_F00D, 4'hF, 0, 0, lat, ec, ok, al, wh);
      model0[0] = 32'h0BAD_F00D;
      axi_write(0, 32'h100, 32'h1234_5678, 4'hF, 0, 0, lat, ec, ok, al, wh);
      n_checks++; if (lat !== 1 || ec !== 1 || !ok) begin n_fail++; $display("FAIL oor_write: got lat=%0d err=%0d ok=%0d expected lat=1 err=1 ok=1", lat, ec, ok); end
      exp_q.push_back(32'hDEAD_BEEF);
      axi_read(0, 32'h100, 0, data, lat, ec, ok);
      e = exp_q.pop_front();
      n_checks++; if (data !== e || ec !== 1) begin n_fail++; $display("FAIL oor_read: got %h err=%0d expected %h err=1", data, ec, e); end
      exp_q.push_back(model0[0]);
      axi_read(0, 32'h0, 0, data, lat, ec, ok);
      e = exp_q.pop_front();
      n_checks++; if (data !== e || ec !== 0) begin n_fail++; $display("FAIL oor_unchanged: got %h err=%0d expected %h err=0", data, ec, e); end
      axi_write(0, 32'hFC, 32'h7777_0FC0, 4'hF, 0, 0, lat, ec, ok, al, wh);
      model0[63] = 32'h7777_0FC0;
      exp_q.push_back(model0[63]);
      axi_read(0, 32'hFC, 0, data, lat, ec, ok);
      e = exp_q.pop_front();
      n_checks++; if (data !== e || ec !== 0) begin n_fail++; $display("FAIL last_word: got %h err=%0d expected %h err=0", data, ec, e); end
      exp_q.push_back(32'hDEAD_BEEF);
      axi_read(1, 32'h7FFF_FFFC, 0, data, lat, ec, ok);
      e = exp_q.pop_front();
      n_checks++; if (data !== e || ec !== 1) begin n_fail++; $display("FAIL below_base: got %h err=%0d expected %h err=1", data, ec, e); end
      exp_q.push_back(32'hDEAD_BEEF);
      axi_read(1, 32'h8000_0040, 0, data, lat, ec, ok);
      e = exp_q.pop_front();
      n_checks++; if (data !== e || ec !== 1) begin n_fail++; $display("FAIL past_end: got %h err=%0d expected %h err=1", data, ec, e); end
   endtask

   task automatic test_collision();
      int wl, wec, al, rl, rec; bit wok, wh, rok; logic [31:0] data, e;
      axi_write(0, 32'h40, 32'h0, 4'hF, 0, 0, wl, wec, wok, al, wh);
      model0[16] = 32'h0;
      exp_q.push_back(model0[16]);
      fork
         axi_write(0, 32'h40, 32'h55, 4'hF, 0, 0, wl, wec, wok, al, wh);
         axi_read(0, 32'h40, 0, data, rl, rec, rok);
      join
      model0[16] = 32'h55;
      e = exp_q.pop_front();
      n_checks++; if (data !== e || rl !== 1 || wl !== 1) begin n_fail++; $display("FAIL collision_old: got %h rlat=%0d wlat=%0d expected %h 1 1", data, rl, wl, e); end
      exp_q.push_back(model0[16]);
      axi_read(0, 32'h40, 0, data, rl, rec, rok);
      e = exp_q.pop_front();
      n_checks++; if (data !== e) begin n_fail++; $display("FAIL collision_new: got %h expected %h", data, e); end
   endtask

   task automatic test_back_to_back();
      int lat, ec, al; bit ok, wh; logic [31:0] data, e, d0, d1, a; logic [3:0] st; int w;
      for (int k = 0; k < 8; k++) begin
         w = int'($urandom_range(63, 0));
         a = 32'(w) * 32'd4;
         d0 = $urandom; d1 = $urandom; st = 4'($urandom_range(15, 0));
         axi_write(0, a, d0, 4'hF, 0, 0, lat, ec, ok, al, wh);
         model0[w] = d0;
         axi_write(0, a, d1, st, k % 3, 0, lat, ec, ok, al, wh);
         model0[w] = merge(model0[w], d1, st);
         exp_q.push_back(model0[w]);
         axi_read(0, a, k % 2, data, lat, ec, ok);
         e = exp_q.pop_front();
         n_checks++; if (data !== e || !ok) begin n_fail++; $display("FAIL b2b_%0d: got %h ok=%0d expected %h ok=1", k, data, ok, e); end
      end
   endtask

   task automatic test_reset_mid();
      logic [5:0] st; int lat, ec; bit ok; logic [31:0] data;
      awaddr[1] = 32'h8000_0010; wdata[1] = 32'h600D_CAFE; wstrb[1] = 4'hF;
      araddr[1] = 32'h8000_0014; bready[1] = 1'b0; rready[1] = 1'b0;
      awvalid[1] = 1'b1; wvalid[1] = 1'b1; arvalid[1] = 1'b1;
      @(negedge clk);
      awvalid[1] = 1'b0; wvalid[1] = 1'b0; arvalid[1] = 1'b0;
      for (int i = 0; i < 10 && !bvalid[1]; i++) @(negedge clk);
      n_checks++; if (bvalid[1] !== 1'b1 || rvalid[1] !== 1'b0) begin n_fail++; $display("FAIL mid_precond: got bvalid=%b rvalid=%b expected 1 0", bvalid[1], rvalid[1]); end
      rst[1] = 1'b1;
      @(negedge clk);
      st = {awready[1], wready[1], arready[1], bvalid[1], rvalid[1], err[1]};
      n_checks++; if (st !== 6'b000000) begin n_fail++; $display("FAIL mid_reset: got %b expected %b", st, 6'b000000); end
      rst[1] = 1'b0;
      @(negedge clk);
      st = {awready[1], wready[1], arready[1], bvalid[1], rvalid[1], err[1]};
      n_checks++; if (st !== 6'b111000) begin n_fail++; $display("FAIL mid_release: got %b expected %b", st, 6'b111000); end
      exp_q.push_back(32'h600D_CAFE);
      axi_read(1, 32'h8000_0010, 0, data, lat, ec, ok);
      n_checks++; if (data !== exp_q.pop_front()) begin n_fail++; $display("FAIL mid_committed: got %h expected %h", data, 32'h600D_CAFE); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_decoupled_strobe();
      test_backpressure();
      test_out_of_range();
      test_collision();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
